cpu: RTL and testbench

// - Vector load/store/arithmetic engine: 512 x 32-bit data RAM, four 16-lane x 32-bit vector registers.
// - Host drives one 3-bit op per clock; bursts of up to 16 words move between host ports, RAM and registers.
// - Lane-wise signed add/multiply: R0 op R1 gives a 64-bit result per lane, split across R2 (low) and R3 (high).

---
 rtl/cpu_pkg.sv | 18 +
 rtl/cpu_if.sv | 14 +
 rtl/cpu_lane_alu.sv | 23 ++
 rtl/cpu.sv | 79 +++++++
 tb/tb_cpu.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-lane vector load/store/arithmetic engine.
package cpu_pkg;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;
   localparam int LANES  = 16;
   localparam int NREGS  = 4;

   typedef enum logic [2:0] {
      RAM_TO_REG = 3'd0,
      REG_TO_RAM = 3'd1,
      ADDI       = 3'd2,
      MULT       = 3'd3,
      RAM_TO_OUT = 3'd4,
      OUT_TO_RAM = 3'd5
   } op_e;

   typedef logic [DATA_W-1:0] vec_t [0:LANES-1];
endpackage

// File: rtl/cpu_if.sv
// Host-side command/data bundle: one op per clock plus burst address and lane data.
interface cpu_if;
   import cpu_pkg::*;

   logic [2:0]        op;
   logic [ADDR_W-1:0] ram_addr;
   logic [3:0]        ram_cnt;
   logic [1:0]        reg_sel;
   vec_t              ram_input;
   vec_t              ram_output;

   modport master (output op, ram_addr, ram_cnt, reg_sel, ram_input, input ram_output);
   modport slave  (input op, ram_addr, ram_cnt, reg_sel, ram_input, output ram_output);
endinterface

// File: rtl/cpu_lane_alu.sv
// One lane of signed arithmetic: 64-bit sum or product of two sign-extended 32-bit words.
module cpu_lane_alu
   import cpu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        op,
   output logic [DATA_W-1:0] lo,
   output logic [DATA_W-1:0] hi
);
   logic signed [2*DATA_W-1:0] a_ext;
   logic signed [2*DATA_W-1:0] b_ext;
   logic signed [2*DATA_W-1:0] res;

   // The low 64 bits of the product of sign-extended operands is the exact signed product.
   always_comb begin
      a_ext = {{DATA_W{a[DATA_W-1]}}, a};
      b_ext = {{DATA_W{b[DATA_W-1]}}, b};
      res   = (op == MULT) ? (a_ext * b_ext) : (a_ext + b_ext);
      lo    = res[DATA_W-1:0];
      hi    = res[2*DATA_W-1:DATA_W];
   end
endmodule

// File: rtl/cpu.sv
// Vector engine top: 512-word RAM, four 16-lane registers, burst address generation and op decode.
module cpu
   import cpu_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   cpu_if.slave  bus
);
   logic [DATA_W-1:0] ram    [0:(2**ADDR_W)-1];
   logic [DATA_W-1:0] vr_reg [0:NREGS-1][0:LANES-1];
   vec_t              out_reg;

   logic [ADDR_W-1:0] lane_addr [0:LANES-1];
   logic [LANES-1:0]  lane_en;
   vec_t              rd_data;
   vec_t              alu_lo;
   vec_t              alu_hi;

   // Lane addresses wrap naturally in ADDR_W bits (511 -> 0).
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_addr[gi] = bus.ram_addr + ADDR_W'(gi);
         assign lane_en[gi]   = (4'(gi) <= bus.ram_cnt);
         assign rd_data[gi]   = ram[lane_addr[gi]];

         cpu_lane_alu u_alu (
            .a  (vr_reg[0][gi]),
            .b  (vr_reg[1][gi]),
            .op (bus.op),
            .lo (alu_lo[gi]),
            .hi (alu_hi[gi])
         );
      end
   endgenerate

   // RAM shares this block so a write coinciding with reset is dropped; RAM itself is never cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LANES; i++) begin
            out_reg[i] <= '0;
            for (int r = 0; r < NREGS; r++) begin
               vr_reg[r][i] <= '0;
            end
         end
      end else begin
         case (bus.op)
            RAM_TO_REG: begin
               for (int i = 0; i < LANES; i++) begin
                  if (lane_en[i]) vr_reg[bus.reg_sel][i] <= rd_data[i];
               end
            end
            REG_TO_RAM: begin
               for (int i = 0; i < LANES; i++) begin
                  if (lane_en[i]) ram[lane_addr[i]] <= vr_reg[bus.reg_sel][i];
               end
            end
            ADDI, MULT: begin
               for (int i = 0; i < LANES; i++) begin
                  vr_reg[2][i] <= alu_lo[i];
                  vr_reg[3][i] <= alu_hi[i];
               end
            end
            RAM_TO_OUT: begin
               for (int i = 0; i < LANES; i++) begin
                  out_reg[i] <= lane_en[i] ? rd_data[i] : '0;
               end
            end
            OUT_TO_RAM: begin
               for (int i = 0; i < LANES; i++) begin
                  if (lane_en[i]) ram[lane_addr[i]] <= bus.ram_input[i];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ram_output = out_reg;
endmodule

// File: tb/tb_cpu.sv
// Randomized and directed check of the vector engine against an array-based reference model.
module tb_cpu;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cpu_if bus ();

   cpu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   logic [31:0] m_ram [0:511];
   logic [31:0] m_reg [0:3][0:15];
   logic [31:0] m_out [0:15];
   bit          out_known = 1'b1;
   vec_t        v;
   vec_t        w;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_out[i] = 32'd0;
         for (int r = 0; r < 4; r++) m_reg[r][i] = 32'd0;
      end
      out_known = 1'b1;
   endtask

   // Reference semantics: every op reads the pre-edge state; no op reads what it writes.
   task automatic model_step(int op, int addr, int cnt, int sel, vec_t din);
      int a;
      longint x;
      longint y;
      for (int i = 0; i < 16; i++) begin
         a = (addr + i) % 512;
         case (op)
            0: if (i <= cnt) m_reg[sel][i] = m_ram[a];
            1: if (i <= cnt) m_ram[a] = m_reg[sel][i];
            2, 3: begin
               x = longint'(signed'(m_reg[0][i]));
               y = longint'(signed'(m_reg[1][i]));
               x = (op == 2) ? x + y : x * y;
               m_reg[2][i] = x[31:0];
               m_reg[3][i] = x[63:32];
            end
            4: m_out[i] = (i <= cnt) ? m_ram[a] : 32'd0;
            5: if (i <= cnt) m_ram[a] = din[i];
            default: ;
         endcase
      end
      if (op == 4) out_known = 1'b1;
   endtask

   task automatic run(int op, int addr, int cnt, int sel, vec_t din);
      bus.op        = 3'(op);
      bus.ram_addr  = 9'(addr);
      bus.ram_cnt   = 4'(cnt);
      bus.reg_sel   = 2'(sel);
      bus.ram_input = din;
      @(posedge clk);
      #1;
      model_step(op, addr, cnt, sel, din);
      $display("txn op=%0d addr=%0d cnt=%0d sel=%0d", op, addr, cnt, sel);
      if (out_known) begin
         for (int i = 0; i < 16; i++) check($sformatf("out[%0d]", i), bus.ram_output[i], m_out[i]);
      end
   endtask

   task automatic fillv(output vec_t o, input logic [31:0] val);
      for (int i = 0; i < 16; i++) o[i] = val;
   endtask

   task automatic randv(output vec_t o);
      for (int i = 0; i < 16; i++) o[i] = $urandom;
   endtask

   task automatic set_reg(int sel, logic [31:0] val);
      vec_t t;
      fillv(t, val);
      run(5, 300, 15, 0, t);
      run(0, 300, 15, sel, t);
   endtask

   task automatic dump_reg(int sel, int addr);
      vec_t t;
      fillv(t, 32'd0);
      run(1, addr, 15, sel, t);
      run(4, addr, 15, 0, t);
   endtask

   task automatic expect_all(string tag, logic [31:0] exp);
      for (int i = 0; i < 16; i++) check($sformatf("%s[%0d]", tag, i), bus.ram_output[i], exp);
   endtask

   initial begin
      fillv(v, 32'd0);
      bus.op = 3'd6; bus.ram_addr = '0; bus.ram_cnt = '0; bus.reg_sel = '0; bus.ram_input = v;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      expect_all("rst_out", 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Read of uninitialised RAM: contents are arbitrary, so output is not checked until reloaded
      bus.op = 3'd4; bus.ram_addr = '0; bus.ram_cnt = 4'd15;
      @(posedge clk);
      #1;
      $display("txn op=4 addr=0 cnt=15 sel=0 (stale)");
      out_known = 1'b0;

      for (int b = 0; b < 32; b++) begin
         randv(v);
         run(5, b * 16, 15, 0, v);
      end
      run(4, 0, 15, 0, v);

      // Write/read round trip
      for (int i = 0; i < 16; i++) v[i] = 32'h1000 + i;
      run(5, 10, 15, 0, v);
      run(4, 10, 15, 0, v);
      for (int i = 0; i < 16; i++) check($sformatf("rt[%0d]", i), bus.ram_output[i], 32'h1000 + i);

      // Add with carry / sign
      set_reg(0, 32'h7FFFFFFF); set_reg(1, 32'h1);
      run(2, 0, 0, 0, v);
      dump_reg(2, 100); expect_all("add1_lo", 32'h80000000);
      dump_reg(3, 120); expect_all("add1_hi", 32'h0);
      set_reg(0, 32'hFFFFFFFF); set_reg(1, 32'hFFFFFFFF);
      run(2, 0, 0, 0, v);
      dump_reg(2, 100); expect_all("add2_lo", 32'hFFFFFFFE);
      dump_reg(3, 120); expect_all("add2_hi", 32'hFFFFFFFF);

      // Multiply
      set_reg(0, 32'h00010000); set_reg(1, 32'h00010000);
      run(3, 0, 0, 0, v);
      dump_reg(2, 100); expect_all("mul1_lo", 32'h0);
      dump_reg(3, 120); expect_all("mul1_hi", 32'h1);
      set_reg(0, 32'hFFFFFFFD); set_reg(1, 32'd5);
      run(3, 0, 0, 0, v);
      dump_reg(2, 100); expect_all("mul2_lo", 32'hFFFFFFF1);
      dump_reg(3, 120); expect_all("mul2_hi", 32'hFFFFFFFF);

      // Short burst: only 200..203 change, lanes past ram_cnt read as zero
      randv(v);
      run(5, 200, 3, 0, v);
      run(4, 196, 15, 0, v);
      run(4, 200, 3, 0, v);
      for (int i = 0; i < 16; i++)
         check($sformatf("short[%0d]", i), bus.ram_output[i], (i <= 3) ? v[i] : 32'd0);

      // Wrap-around burst
      randv(v);
      run(5, 510, 15, 0, v);
      run(0, 510, 15, 1, v);
      dump_reg(1, 50);
      for (int i = 0; i < 16; i++) check($sformatf("wrap_reg[%0d]", i), bus.ram_output[i], v[i]);
      run(4, 0, 13, 0, v);
      for (int i = 0; i < 14; i++) check($sformatf("wrap_ram[%0d]", i), bus.ram_output[i], v[i + 2]);

      // Randomized ops including no-ops, with periodic register dumps
      for (int n = 0; n < 400; n++) begin
         randv(w);
         run($urandom_range(0, 7), $urandom_range(0, 511), $urandom_range(0, 15),
             $urandom_range(0, 3), w);
         if (n % 40 == 39) begin
            for (int r = 0; r < 4; r++) dump_reg(r, $urandom_range(0, 511));
         end
      end

      // Reset during a RAM write: write dropped, registers and output cleared at once
      randv(w);
      bus.op = 3'd5; bus.ram_addr = 9'd20; bus.ram_cnt = 4'd15; bus.ram_input = w;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      expect_all("async_rst_out", 32'd0);
      @(posedge clk);
      #1;
      $display("txn op=5 addr=20 cnt=15 sel=0 (under reset)");
      @(negedge clk);
      rst_n = 1'b1;
      run(4, 20, 15, 0, w);
      for (int r = 0; r < 4; r++) dump_reg(r, 400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
